// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and field helpers
// for the vector-math datapath.
package fp32_pkg;

  typedef logic [31:0] float_t;

  localparam int     FP_BIAS     = 127;
  localparam float_t FP_QNAN     = 32'h7FC00000;
  localparam float_t FP_POS_INF  = 32'h7F800000;
  localparam float_t FP_NEG_INF  = 32'hFF800000;
  localparam float_t FP_POS_ZERO = 32'h00000000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } dp_state_e;

  function automatic logic fp_sign(float_t f);
    return f[31];
  endfunction

  function automatic logic [7:0] fp_exp(float_t f);
    return f[30:23];
  endfunction

  function automatic logic [22:0] fp_man(float_t f);
    return f[22:0];
  endfunction

endpackage

// File: rtl/vec_vec_to_scalar.sv
// Two float vectors in, one float scalar out,
// with the clock/reset that sequences the reduction.
interface vec_vec_to_scalar #(
  parameter int VECTOR_LEN = 4
);
  import fp32_pkg::*;

  logic                           clk;
  logic                           rst;
  logic [VECTOR_LEN-1:0][31:0]    vec1;
  logic [VECTOR_LEN-1:0][31:0]    vec2;
  float_t                         result;
  logic                           done;

  modport DUT (
    input  clk,
    input  rst,
    input  vec1,
    input  vec2,
    output result,
    output done
  );

endinterface

// File: rtl/fp_mul_add.sv
// y = round(round(a*b) + c), RNE, flush-to-zero,
// canonical quiet NaN on any invalid case.
module fp_mul_add
  import fp32_pkg::*;
(
  input  float_t a,
  input  float_t b,
  input  float_t c,
  output float_t y
);

  function automatic logic [4:0] lzc27(logic [26:0] v);
    logic [4:0] n;
    logic       f;
    n = 5'd0;
    f = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!f && v[i]) f = 1'b1;
      else if (!f) n = n + 5'd1;
    end
    return n;
  endfunction

  float_t              p;
  logic                a_z, a_i, a_n;
  logic                b_z, b_i, b_n;
  logic                ps, pg, pst;
  logic [47:0]         pm;
  logic [23:0]         pn;
  logic [24:0]         pr;
  logic signed [10:0]  pe;

  always_comb begin
    ps  = fp_sign(a) ^ fp_sign(b);
    a_z = fp_exp(a) == 8'd0;
    a_i = fp_exp(a) == 8'hFF && fp_man(a) == 23'd0;
    a_n = fp_exp(a) == 8'hFF && fp_man(a) != 23'd0;
    b_z = fp_exp(b) == 8'd0;
    b_i = fp_exp(b) == 8'hFF && fp_man(b) == 23'd0;
    b_n = fp_exp(b) == 8'hFF && fp_man(b) != 23'd0;
    pm  = {24'd0, 1'b1, fp_man(a)} * {24'd0, 1'b1, fp_man(b)};
    pe  = $signed({3'b000, fp_exp(a)})
        + $signed({3'b000, fp_exp(b)})
        - 11'(FP_BIAS);
    if (pm[47]) begin
      pn  = pm[47:24];
      pg  = pm[23];
      pst = |pm[22:0];
      pe  = pe + 11'sd1;
    end else begin
      pn  = pm[46:23];
      pg  = pm[22];
      pst = |pm[21:0];
    end
    pr = {1'b0, pn} + {24'd0, pg & (pst | pn[0])};
    if (pr[24]) pe = pe + 11'sd1;
    if (a_n || b_n || (a_i && b_z) || (a_z && b_i))
      p = FP_QNAN;
    else if (a_i || b_i)
      p = {ps, 8'hFF, 23'd0};
    else if (a_z || b_z)
      p = {ps, 31'd0};
    else if (pe >= 11'sd255)
      p = {ps, 8'hFF, 23'd0};
    else if (pe <= 11'sd0)
      p = {ps, 31'd0};
    else
      p = {ps, pe[7:0], pr[22:0]};
  end

  float_t              big, sml;
  logic                x_z, x_i, x_n;
  logic                c_z, c_i, c_n;
  logic                swap, diff, canc, rs;
  logic [7:0]          d8;
  logic [4:0]          sh, lz;
  logic [49:0]         sfull;
  logic [26:0]         bm, sm, nm;
  logic [27:0]         sum;
  logic [24:0]         rr;
  logic signed [10:0]  re;

  always_comb begin
    x_z   = fp_exp(p) == 8'd0;
    x_i   = fp_exp(p) == 8'hFF && fp_man(p) == 23'd0;
    x_n   = fp_exp(p) == 8'hFF && fp_man(p) != 23'd0;
    c_z   = fp_exp(c) == 8'd0;
    c_i   = fp_exp(c) == 8'hFF && fp_man(c) == 23'd0;
    c_n   = fp_exp(c) == 8'hFF && fp_man(c) != 23'd0;
    swap  = c[30:0] > p[30:0];
    big   = swap ? c : p;
    sml   = swap ? p : c;
    diff  = fp_sign(big) != fp_sign(sml);
    d8    = fp_exp(big) - fp_exp(sml);
    // 31 places already pushes every small bit into sticky
    sh    = (d8 > 8'd31) ? 5'd31 : d8[4:0];
    sfull = {1'b1, fp_man(sml), 26'd0} >> sh;
    sm    = {sfull[49:24], |sfull[23:0]};
    bm    = {1'b1, fp_man(big), 3'b000};
    re    = $signed({3'b000, fp_exp(big)});
    rs    = fp_sign(big);
    lz    = 5'd0;
    if (diff) begin
      sum = {1'b0, bm} - {1'b0, sm};
      lz  = lzc27(sum[26:0]);
      nm  = sum[26:0] << lz;
      re  = re - $signed({6'd0, lz});
    end else begin
      sum = {1'b0, bm} + {1'b0, sm};
      if (sum[27]) begin
        nm = {sum[27:2], sum[1] | sum[0]};
        re = re + 11'sd1;
      end else begin
        nm = sum[26:0];
      end
    end
    canc = diff && sum[26:0] == 27'd0;
    rr = {1'b0, nm[26:3]}
       + {24'd0, nm[2] & (nm[1] | nm[0] | nm[3])};
    if (rr[24]) re = re + 11'sd1;
    if (x_n || c_n || (x_i && c_i && fp_sign(p) != fp_sign(c)))
      y = FP_QNAN;
    else if (x_i)
      y = p;
    else if (c_i)
      y = c;
    else if (x_z && c_z)
      y = {fp_sign(p) & fp_sign(c), 31'd0};
    else if (x_z)
      y = c;
    else if (c_z)
      y = p;
    else if (canc)
      y = FP_POS_ZERO;
    else if (re >= 11'sd255)
      y = rs ? FP_NEG_INF : FP_POS_INF;
    else if (re <= 11'sd0)
      y = {rs, 31'd0};
    else
      y = {rs, re[7:0], rr[22:0]};
  end

  logic unused_hidden;
  assign unused_hidden = pr[23] ^ rr[23];

endmodule

// File: rtl/dot_product.sv
// Sequential fp32 dot product: one MAC per clock after
// reset release, then a sticky done with the held sum.
module dot_product
  import fp32_pkg::*;
(
  vec_vec_to_scalar.DUT bus
);

  localparam int unsigned N  = bus.VECTOR_LEN;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  dp_state_e       state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  float_t          acc_q, acc_d;
  float_t          mac_y;

  fp_mul_add u_mac (
    .a (bus.vec1[idx_q]),
    .b (bus.vec2[idx_q]),
    .c (acc_q),
    .y (mac_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_RUN: begin
        acc_d = mac_y;
        if (idx_q == IW'(N - 1)) state_d = ST_DONE;
        else idx_d = idx_q + 1'b1;
      end
      ST_DONE: begin
      end
    endcase
  end

  always_ff @(posedge bus.clk) begin
    if (bus.rst) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      acc_q   <= FP_POS_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.result = acc_q;
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_dot_product.sv
// Directed-vector bench for dot_product: latency, rounding,
// specials, mid-run reset and hold-after-done behaviour.
module tb_dot_product;

  vec_vec_to_scalar #(.VECTOR_LEN(4)) vif ();

  dot_product dut (
    .bus (vif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  always #5 vif.clk = ~vif.clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vif.clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] a0, a1, a2, a3,
                         input logic [31:0] b0, b1, b2, b3);
    vif.vec1[0] = a0; vif.vec1[1] = a1;
    vif.vec1[2] = a2; vif.vec1[3] = a3;
    vif.vec2[0] = b0; vif.vec2[1] = b1;
    vif.vec2[2] = b2; vif.vec2[3] = b3;
  endtask

  task automatic run(input string tag, input logic [31:0] exp);
    vif.rst = 1'b1;
    tick();
    check({tag, "_rst_done"}, {31'd0, vif.done}, 32'd0);
    check({tag, "_rst_res"}, vif.result, 32'd0);
    vif.rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check({tag, "_busy"}, {31'd0, vif.done}, 32'd0);
    end
    tick();
    check({tag, "_done"}, {31'd0, vif.done}, 32'd1);
    check({tag, "_res"}, vif.result, exp);
  endtask

  initial begin
    vif.clk = 1'b0;
    vif.rst = 1'b1;
    set_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick();
    tick();

    run("sum5", 32'h40A00000);

    set_vec(32'h3FC00000, 32'hC0000000, 32'h3F000000, 32'h40400000,
            32'h40000000, 32'h3F800000, 32'h40800000, 32'hBF800000);
    run("cancel", 32'h00000000);

    set_vec(32'h7F61B1E6, 32'h7F61B1E6, 32'h00000000, 32'h00000000,
            32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000);
    run("ovf", 32'h7F800000);

    set_vec(32'h3F800000, 32'h7F800001, 32'h3F800000, 32'h3F800000,
            32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("nan", 32'h7FC00000);

    set_vec(32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
            32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000);
    run("infx0", 32'h7FC00000);

    set_vec(32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000,
            32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("tie_even", 32'h3F800000);

    set_vec(32'h3F800000, 32'h34400000, 32'h00000000, 32'h00000000,
            32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("tie_up", 32'h3F800002);

    set_vec(32'h3F800001, 32'h00000000, 32'h00000000, 32'h00000000,
            32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("mul_rnd", 32'h3F800002);

    set_vec(32'h00400000, 32'h3F800000, 32'h00000000, 32'h00000000,
            32'h7E800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("daz", 32'h3F800000);

    set_vec(32'hC0400000, 32'h3F000000, 32'h00000000, 32'h00000000,
            32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    run("neg", 32'hC0B00000);

    set_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    vif.rst = 1'b1;
    tick();
    vif.rst = 1'b0;
    tick();
    tick();
    check("mid_part", vif.result, 32'h40400000);
    vif.rst = 1'b1;
    tick();
    check("mid_rst_done", {31'd0, vif.done}, 32'd0);
    check("mid_rst_res", vif.result, 32'd0);
    vif.rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_busy", {31'd0, vif.done}, 32'd0);
    end
    tick();
    check("mid_done", {31'd0, vif.done}, 32'd1);
    check("mid_res", vif.result, 32'h40A00000);

    for (int k = 0; k < 10; k++) begin
      set_vec($urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom);
      tick();
      check("hold_done", {31'd0, vif.done}, 32'd1);
      check("hold_res", vif.result, 32'h40A00000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_product.md
# dot_product

Sequential IEEE-754 single-precision dot-product engine for the vector-math layer of the ANN datapath. After reset is released, it multiply-accumulates `VECTOR_LEN` element pairs from two float vectors, one pair per clock. It then presents the scalar sum and raises a sticky `done` flag. It connects to the rest of the design through the `vec_vec_to_scalar` interface, via that interface's `DUT` modport.

## Interface
Parameters (carried by `vec_vec_to_scalar`):
- `VECTOR_LEN`, default 4: number of elements per vector; must be ≥1.

Ports (interface signals, as seen through modport `DUT`):
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `vec1`  input  `VECTOR_LEN` × 32: operand vector A; each element is IEEE-754 binary32.
- `vec2`  input  `VECTOR_LEN` × 32: operand vector B; each element is IEEE-754 binary32.
- `result`  output  32: binary32 dot product.
- `done`  output  1: result valid; sticky until the next reset.

## Operation
- Computes `acc = Σ vec1[i]*vec2[i]` for i = 0..`VECTOR_LEN`-1, in ascending index order.
- Each product is rounded to binary32 before it is added to `acc`. This is not a fused operation: there are two roundings per step.
- Rounding mode is round-to-nearest-even for both the multiply and the add.
- `acc` starts at +0.0.
- Subnormal inputs are treated as signed zero. Subnormal results are flushed to signed zero.
- Exact cancellation (x + (−x)) yields +0.0.
- Any NaN operand, inf×0, or +inf + −inf produces canonical quiet NaN 0x7FC00000. NaN is sticky through the rest of the accumulation.
- A finite overflow produces ±inf (0x7F800000 / 0xFF800000).
- Operands are read live, element `idx` in the cycle that processes it. `vec1` and `vec2` must therefore stay stable from reset release until `done` is high.
- There is no start strobe: reset release is the start.
- State machine:
  - RUN: reset state, `idx` = 0. Each cycle, `acc <= acc + vec1[idx]*vec2[idx]` and `idx` increments. When `idx` = `VECTOR_LEN`-1, the next state is DONE.
  - DONE: holds `acc`, `done` = 1, and ignores inputs.
- `result` is `acc` continuously. It is only meaningful while `done` = 1.

## Timing
- Reset values: `done` = 0, `result` = 0x00000000, `idx` = 0, state RUN.
- Let E0 be the first rising edge with `rst` = 0. Element i is accumulated at edge E0+i.
- `done` rises after the same edge that accumulates the last element, i.e. edge E0+`VECTOR_LEN`-1. Latency is `VECTOR_LEN` cycles from reset release.
- `result` is valid in the same cycle `done` rises.
- `done` and `result` hold indefinitely until `rst` is asserted.
- Reset asserted mid-operation or in DONE: at the next edge, return to RUN/idx 0, acc +0, `done` 0. The partial sum is discarded.
- The multiply-add path is combinational within one cycle. No pipelining is required at the 50 MHz target.

## Structure
- Package `fp32_pkg` holds:
  - `typedef logic [31:0] float_t`
  - constants `FP_BIAS` = 127, `FP_QNAN` = 32'h7FC00000, `FP_POS_INF`, `FP_NEG_INF`, `FP_POS_ZERO`
  - field-extract helper functions for sign, exponent and mantissa
- One sub-module, `fp_mul_add`, is combinational: `a*b` rounded, then `+c` rounded, with the special-case handling above.
- `dot_product` itself contains only the index counter, the accumulator register and the RUN/DONE FSM.

## Test plan
- `vec1` = {1,1,1,1}, `vec2` = {2,1,1,1`}, held through reset, then `rst` released → `done` rises 4 cycles later with `result` = 0x40A00000 (5.0).
- `vec1` = {1.5,−2,0.5,3}, `vec2` = {2,1,4,−1} → `result` = 0x00000000 (+0.0), `done` = 1 after 4 cycles.
- `vec1` = {3e38,3e38,0,0}, `vec2` = {2,2,1,1} → `result` = 0x7F800000 (+inf).
- `vec1`[1] = NaN, other elements finite; separately inf×0 → `result` = 0x7FC00000 in both cases.
- Assert `rst` for one cycle after 2 elements, with vectors as in the first scenario → `done` drops to 0, then rises exactly 4 cycles after the second release with `result` = 5.0.
- After `done`, change `vec1`/`vec2` for 10 cycles → `result` and `done` remain unchanged.
